// File: rtl/fifo_nibble_packer_pkg.sv
// fifo_pack_pkg
//   Shared definitions for the nibble FIFO read-side packer: the packer state
//   encoding, default entry width / lane count, and the helper that sizes the
//   out_count field.
package fifo_pack_pkg;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_DATA = 2'd1,
    OUT       = 2'd2
  } pack_state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LANES = 2;

  // out_count must represent 0..lanes inclusive.
  function automatic int cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/fifo_nibble_packer_if.sv
// fifo_nibble_packer_if
//   Bundles the FIFO read port, the flush request and the downstream
//   valid/ready word port of the nibble packer.
//   Signals:
//     fifo_data  [WIDTH]        FIFO data_out (valid the cycle after fifo_read)
//     fifo_empty                FIFO empty flag
//     fifo_read                 one-cycle read strobe to the FIFO
//     flush                     emit a partially filled word (level-sampled)
//     out_data   [WIDTH*LANES]  packed word, lane 0 in the LSBs
//     out_count  [CW]           number of valid lanes in out_data
//     out_valid / out_ready     downstream handshake
//     out_parity                only with FIFO_PACKER_PARITY_EN defined
//   Modports: master = packer side, slave = FIFO/downstream environment side.
interface fifo_nibble_packer_if
  import fifo_pack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int CW    = cnt_width(LANES)
);

  logic [WIDTH-1:0]       fifo_data;
  logic                   fifo_empty;
  logic                   fifo_read;
  logic                   flush;
  logic [WIDTH*LANES-1:0] out_data;
  logic [CW-1:0]          out_count;
  logic                   out_valid;
  logic                   out_ready;
`ifdef FIFO_PACKER_PARITY_EN
  logic                   out_parity;
`endif

  modport master (
    input  fifo_data,
    input  fifo_empty,
    input  flush,
    input  out_ready,
    output fifo_read,
    output out_data,
    output out_count,
`ifdef FIFO_PACKER_PARITY_EN
    output out_parity,
`endif
    output out_valid
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    output flush,
    output out_ready,
    input  fifo_read,
    input  out_data,
    input  out_count,
`ifdef FIFO_PACKER_PARITY_EN
    input  out_parity,
`endif
    input  out_valid
  );

endinterface

// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer
//   Drains WIDTH-bit entries from the nibble FIFO and packs LANES consecutive
//   entries into one word presented on a valid/ready handshake. A flush
//   forces out a partially filled word; unused upper lanes read as zero.
//   Optional feature macro: FIFO_PACKER_PARITY_EN adds out_parity, the XOR of
//   all bits of the valid lanes, registered with out_data.
//   Ports:
//     rd_clk  FIFO read clock
//     reset   synchronous, active-high
//     pk      fifo_nibble_packer_if.master (FIFO read port, flush, word port)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   FILL      | idle between entries; issue a read or honour a flush
//   WAIT_DATA | one cycle; FIFO data of the last read is captured
//   OUT       | word held on out_data until out_valid && out_ready
module fifo_nibble_packer
  import fifo_pack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int CW    = cnt_width(LANES)
) (
  input  logic                 rd_clk,
  input  logic                 reset,
  fifo_nibble_packer_if.master pk
);

  localparam int LCW = $clog2(LANES);

  pack_state_e            state_q;
  logic [LCW-1:0]         lane_cnt_q;
  logic [WIDTH-1:0]       lane_q [LANES];
  logic                   flush_pend_q;
  logic [WIDTH*LANES-1:0] out_data_q;
  logic [CW-1:0]          out_count_q;
  logic                   out_valid_q;

  logic [WIDTH-1:0]       lane_d [LANES];
  logic [CW-1:0]          emit_cnt_d;
  logic [WIDTH*LANES-1:0] word_d;

  // Lane buffer including the entry being captured this cycle, and the word
  // that would be emitted now with lanes at or above the valid count zeroed.
  always_comb begin
    lane_d = lane_q;
    if (state_q == WAIT_DATA) begin
      lane_d[lane_cnt_q] = pk.fifo_data;
    end
    emit_cnt_d = (state_q == WAIT_DATA) ? CW'(lane_cnt_q) + CW'(1) : CW'(lane_cnt_q);
    word_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < emit_cnt_d) begin
        word_d[i*WIDTH +: WIDTH] = lane_d[i];
      end
    end
  end

  // The read strobe is decoded from the state register but qualified by the
  // live empty flag: the FIFO must only see a read in a cycle where it
  // reports data available, and a registered strobe would lag by one cycle.
  assign pk.fifo_read = !reset && (state_q == FILL) && !pk.fifo_empty;

`ifdef FIFO_PACKER_PARITY_EN
  logic out_parity_q;
  assign pk.out_parity = out_parity_q;
`endif

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q      <= FILL;
      lane_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
      end
`ifdef FIFO_PACKER_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (!pk.fifo_empty) begin
            state_q <= WAIT_DATA;
            // A flush coinciding with a read covers the entry now in flight.
            if (pk.flush) begin
              flush_pend_q <= 1'b1;
            end
          end else if ((pk.flush || flush_pend_q) && (lane_cnt_q != '0)) begin
            state_q      <= OUT;
            out_valid_q  <= 1'b1;
            out_data_q   <= word_d;
            out_count_q  <= emit_cnt_d;
            lane_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
`ifdef FIFO_PACKER_PARITY_EN
            out_parity_q <= ^word_d;
`endif
          end
        end

        WAIT_DATA: begin
          lane_q <= lane_d;
          if ((lane_cnt_q == LCW'(LANES - 1)) || pk.flush || flush_pend_q) begin
            state_q      <= OUT;
            out_valid_q  <= 1'b1;
            out_data_q   <= word_d;
            out_count_q  <= emit_cnt_d;
            lane_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
`ifdef FIFO_PACKER_PARITY_EN
            out_parity_q <= ^word_d;
`endif
          end else begin
            state_q    <= FILL;
            lane_cnt_q <= lane_cnt_q + LCW'(1);
          end
        end

        OUT: begin
          // A flush seen while holding a word is kept for the next word.
          if (pk.flush) begin
            flush_pend_q <= 1'b1;
          end
          if (pk.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= FILL;
          end
        end

        default: state_q <= FILL;
      endcase
    end
  end

  assign pk.out_data  = out_data_q;
  assign pk.out_count = out_count_q;
  assign pk.out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// tb_fifo_nibble_packer
//   Directed bench for fifo_nibble_packer (WIDTH=4, LANES=2) with a small
//   behavioural FIFO whose data_out registers one cycle after a read.
//   Define FIFO_PACKER_PARITY_EN to also exercise out_parity.
module tb_fifo_nibble_packer;

  logic rd_clk;
  logic reset;

  fifo_nibble_packer_if #(.WIDTH(4), .LANES(2)) bus ();

  fifo_nibble_packer #(.WIDTH(4), .LANES(2)) dut (
    .rd_clk (rd_clk),
    .reset  (reset),
    .pk     (bus)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // Behavioural FIFO: pushes from the stimulus side, pops on fifo_read.
  logic [3:0] mem [32];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [3:0] fd_q = 4'h0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.fifo_data  = fd_q;

  always @(posedge rd_clk) begin
    if (bus.fifo_read) begin
      fd_q   <= mem[rd_ptr % 32];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [3:0] v);
    mem[wr_ptr % 32] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  int n_vec = 0;
  int n_err = 0;

  // Observation record, reset by clear_stats.
  int         t;
  int         n_reads;
  int         rd_t [8];
  int         n_valid;
  int         fv_t;
  int         n_hs;
  logic [7:0] w_data [8];
  logic [1:0] w_cnt [8];
  logic       w_par [8];
  int         w_t [8];
  logic       was_valid;
  logic [7:0] held_data;
  logic       v_changed;

  task automatic clear_stats();
    t = 0; n_reads = 0; n_valid = 0; fv_t = -1; n_hs = 0;
    was_valid = 1'b0; held_data = 8'h00; v_changed = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_t[i] = -1; w_data[i] = 8'h00; w_cnt[i] = 2'd0; w_par[i] = 1'b0; w_t[i] = -1;
    end
  endtask

  // Runs n cycles; inputs are changed by callers at 1 time unit after the edge,
  // outputs are observed 3 units after the edge.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      #2;
      if (bus.fifo_read) begin
        if (n_reads < 8) rd_t[n_reads] = t;
        n_reads++;
      end
      if (bus.out_valid) begin
        if (n_valid == 0) fv_t = t;
        n_valid++;
        if (was_valid && (bus.out_data != held_data)) v_changed = 1'b1;
        held_data = bus.out_data;
        if (bus.out_ready) begin
          if (n_hs < 8) begin
            w_data[n_hs] = bus.out_data;
            w_cnt[n_hs]  = bus.out_count;
            w_t[n_hs]    = t;
`ifdef FIFO_PACKER_PARITY_EN
            w_par[n_hs]  = bus.out_parity;
`endif
          end
          n_hs++;
        end
      end
      was_valid = bus.out_valid && !bus.out_ready;
      @(posedge rd_clk);
      #1;
      t++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge rd_clk);
    #3;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", bus.out_valid); end
    n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %0h exp 00", bus.out_data); end
    n_vec++; if (bus.out_count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", bus.out_count); end
    n_vec++; if (bus.fifo_read !== 1'b0) begin n_err++; $display("FAIL reset_read got %0b exp 0", bus.fifo_read); end
    @(posedge rd_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_full_word();
    clear_stats();
    bus.out_ready = 1'b1;
    push(4'h3);
    push(4'hA);
    run_cycles(10);
    n_vec++; if (n_reads !== 2) begin n_err++; $display("FAIL full_reads got %0d exp 2", n_reads); end
    n_vec++; if (rd_t[0] !== 0) begin n_err++; $display("FAIL full_first_read got %0d exp 0", rd_t[0]); end
    n_vec++; if (rd_t[1] - rd_t[0] !== 2) begin n_err++; $display("FAIL full_read_gap got %0d exp 2", rd_t[1] - rd_t[0]); end
    n_vec++; if (n_valid !== 1) begin n_err++; $display("FAIL full_valid_cycles got %0d exp 1", n_valid); end
    n_vec++; if (fv_t !== 4) begin n_err++; $display("FAIL full_valid_time got %0d exp 4", fv_t); end
    n_vec++; if (w_data[0] !== 8'hA3) begin n_err++; $display("FAIL full_data got %0h exp a3", w_data[0]); end
    n_vec++; if (w_cnt[0] !== 2'd2) begin n_err++; $display("FAIL full_count got %0d exp 2", w_cnt[0]); end
  endtask

  task automatic test_flush_partial();
    clear_stats();
    bus.out_ready = 1'b1;
    push(4'h5);
    run_cycles(4);
    bus.flush = 1'b1;
    run_cycles(1);
    bus.flush = 1'b0;
    run_cycles(4);
    n_vec++; if (n_reads !== 1) begin n_err++; $display("FAIL flush_reads got %0d exp 1", n_reads); end
    n_vec++; if (fv_t !== 5) begin n_err++; $display("FAIL flush_latency got %0d exp 5", fv_t); end
    n_vec++; if (w_data[0] !== 8'h05) begin n_err++; $display("FAIL flush_data got %0h exp 05", w_data[0]); end
    n_vec++; if (w_cnt[0] !== 2'd1) begin n_err++; $display("FAIL flush_count got %0d exp 1", w_cnt[0]); end
    // Next word must start again at lane 0.
    clear_stats();
    push(4'h6);
    push(4'h9);
    run_cycles(8);
    n_vec++; if (w_data[0] !== 8'h96) begin n_err++; $display("FAIL flush_next_data got %0h exp 96", w_data[0]); end
    n_vec++; if (w_cnt[0] !== 2'd2) begin n_err++; $display("FAIL flush_next_count got %0d exp 2", w_cnt[0]); end
  endtask

  task automatic test_flush_empty();
    clear_stats();
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    run_cycles(1);
    bus.flush = 1'b0;
    run_cycles(8);
    n_vec++; if (n_valid !== 0) begin n_err++; $display("FAIL empty_flush_valid got %0d exp 0", n_valid); end
    n_vec++; if (n_reads !== 0) begin n_err++; $display("FAIL empty_flush_reads got %0d exp 0", n_reads); end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    bus.out_ready = 1'b0;
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    run_cycles(15);
    n_vec++; if (n_reads !== 2) begin n_err++; $display("FAIL hold_reads got %0d exp 2", n_reads); end
    n_vec++; if (fv_t !== 4) begin n_err++; $display("FAIL hold_valid_time got %0d exp 4", fv_t); end
    n_vec++; if (held_data !== 8'h21) begin n_err++; $display("FAIL hold_data got %0h exp 21", held_data); end
    bus.out_ready = 1'b1;
    run_cycles(8);
    n_vec++; if (v_changed !== 1'b0) begin n_err++; $display("FAIL hold_stable got %0b exp 0", v_changed); end
    n_vec++; if (w_t[0] !== 15) begin n_err++; $display("FAIL hold_accept_time got %0d exp 15", w_t[0]); end
    n_vec++; if (rd_t[2] !== 16) begin n_err++; $display("FAIL resume_read_time got %0d exp 16", rd_t[2]); end
    n_vec++; if (w_data[0] !== 8'h21) begin n_err++; $display("FAIL hold_word0 got %0h exp 21", w_data[0]); end
    n_vec++; if (w_data[1] !== 8'h43) begin n_err++; $display("FAIL hold_word1 got %0h exp 43", w_data[1]); end
    n_vec++; if (w_t[1] !== 20) begin n_err++; $display("FAIL hold_word1_time got %0d exp 20", w_t[1]); end
  endtask

  task automatic test_reset_midword();
    clear_stats();
    bus.out_ready = 1'b1;
    push(4'h7);
    run_cycles(1);
    reset = 1'b1;
    run_cycles(1);
    reset = 1'b0;
    #2;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %0b exp 0", bus.out_valid); end
    n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL midrst_data got %0h exp 00", bus.out_data); end
    n_vec++; if (bus.out_count !== 2'd0) begin n_err++; $display("FAIL midrst_count got %0d exp 0", bus.out_count); end
    n_vec++; if (bus.fifo_read !== 1'b0) begin n_err++; $display("FAIL midrst_read got %0b exp 0", bus.fifo_read); end
    @(posedge rd_clk);
    #1;
    clear_stats();
    push(4'h1);
    push(4'h2);
    run_cycles(8);
    n_vec++; if (w_data[0] !== 8'h21) begin n_err++; $display("FAIL midrst_next_data got %0h exp 21", w_data[0]); end
    n_vec++; if (w_cnt[0] !== 2'd2) begin n_err++; $display("FAIL midrst_next_count got %0d exp 2", w_cnt[0]); end
  endtask

`ifdef FIFO_PACKER_PARITY_EN
  task automatic test_parity();
    clear_stats();
    bus.out_ready = 1'b1;
    push(4'h1);
    push(4'h2);
    push(4'h1);
    push(4'h3);
    run_cycles(14);
    n_vec++; if (w_data[0] !== 8'h21) begin n_err++; $display("FAIL par_data0 got %0h exp 21", w_data[0]); end
    n_vec++; if (w_par[0] !== 1'b0) begin n_err++; $display("FAIL par_bit0 got %0b exp 0", w_par[0]); end
    n_vec++; if (w_data[1] !== 8'h31) begin n_err++; $display("FAIL par_data1 got %0h exp 31", w_data[1]); end
    n_vec++; if (w_par[1] !== 1'b1) begin n_err++; $display("FAIL par_bit1 got %0b exp 1", w_par[1]); end
  endtask
`endif

  initial begin
    clear_stats();
    test_reset();
    test_full_word();
    test_flush_partial();
    test_flush_empty();
    test_back_to_back();
    test_reset_midword();
`ifdef FIFO_PACKER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
